round_scheduler: RTL and testbench

Sequences the encoder's per-step datapath controllers (theta, rho, pi, chi, revaluate/iota) through every step of every round. Each step controller has a start/done handshake. This block launches them one at a time, in fixed order, and repeats the sequence for NUM_ROUNDS rounds. It publishes the current round index for the round-constant logic and raises a single done pulse to the top level. It also provides an abort path and a per-step watchdog.

---
 rtl/round_scheduler.sv | 131 +++++++++++++
 tb/tb_round_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/round_scheduler.sv
// Round/step sequencer: launches each step controller in order for every round,
// with a per-step watchdog and an abort path back to idle.
module round_scheduler #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned NUM_ROUNDS = 24,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned RW         = 5,
    parameter int unsigned SW         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [SW-1:0]         stage_idx,
    output logic [RW-1:0]         round_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StAdvance,
        StDone,
        StError
    } state_e;

    state_e                  state_q, state_d;
    logic [SW-1:0]           stage_idx_d;
    logic [RW-1:0]           round_idx_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    sel_done;
    logic [NUM_STAGES-1:0]   stage_start_d;

    // Only the selected step's done bit matters; stale bits of other steps are ignored.
    always_comb begin
        sel_done = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (stage_idx == SW'(i)) begin
                sel_done = stage_done[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx;
        round_idx_d = round_idx;
        timer_d     = timer_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    stage_idx_d = '0;
                    round_idx_d = '0;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (sel_done) begin
                    state_d = StAdvance;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAdvance: begin
                if (stage_idx != SW'(NUM_STAGES - 1)) begin
                    stage_idx_d = stage_idx + 1'b1;
                    state_d     = StLaunch;
                end else begin
                    stage_idx_d = '0;
                    if (round_idx == RW'(NUM_ROUNDS - 1)) begin
                        state_d = StDone;
                    end else begin
                        round_idx_d = round_idx + 1'b1;
                        state_d     = StLaunch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StError;
            default: state_d = StIdle;
        endcase
        // Abort overrides every other transition, including done and error.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        stage_start_d = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stage_start_d[i] = (state_d == StLaunch) && (stage_idx_d == SW'(i));
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            stage_idx   <= '0;
            round_idx   <= '0;
            timer_q     <= '0;
            stage_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_idx   <= stage_idx_d;
            round_idx   <= round_idx_d;
            timer_q     <= timer_d;
            stage_start <= stage_start_d;
            busy        <= (state_d != StIdle);
            done        <= (state_d == StDone);
            error       <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_round_scheduler.sv
// Directed bench for round_scheduler (TIMEOUT=8): nominal, minimum latency, collision,
// watchdog, abort with ignored start, and asynchronous reset mid-run.
module tb_round_scheduler;

    localparam int NS = 5;
    localparam int NR = 24;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_start;
    logic [2:0]    stage_idx;
    logic [4:0]    round_idx;
    logic          busy;
    logic          done;
    logic          error;

    round_scheduler #(
        .NUM_STAGES(NS),
        .NUM_ROUNDS(NR),
        .TIMEOUT   (8),
        .RW        (5),
        .SW        (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .stage_done (stage_done),
        .stage_start(stage_start),
        .stage_idx  (stage_idx),
        .round_idx  (round_idx),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Run bookkeeping; cycle 1 is the cycle after the edge that samples start.
    int cyc, launches, d, hang, age, pend, done_cyc, err_cyc, n_done, last_launch;
    bit pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_run(input int delay, input int hang_launch);
        cyc        = 0;
        launches   = 0;
        pending    = 1'b0;
        age        = 0;
        done_cyc   = -1;
        err_cyc    = -1;
        n_done     = 0;
        d          = delay;
        hang       = hang_launch;
        stage_done = '0;
        start      = 1'b1;
    endtask

    // Advance to the next falling edge, check any launch, and model the step controllers.
    task automatic step();
        @(negedge clk);
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (error && err_cyc < 0) err_cyc = cyc;
        if (stage_start != '0) begin
            check("launch_onehot", 32'(stage_start), 32'(1) << (launches % NS));
            check("launch_stage_idx", 32'(stage_idx), launches % NS);
            check("launch_round_idx", 32'(round_idx), launches / NS);
            check("launch_cycle", cyc, 1 + launches * (2 + d));
            pend              = launches % NS;
            stage_done[pend]  = 1'b0;
            age               = 0;
            pending           = 1'b1;
            last_launch       = cyc;
            launches++;
        end else if (pending) begin
            age++;
            if (age == d && (launches - 1) != hang) stage_done[pend] = 1'b1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        stage_done = '0;
        d          = 4;
        hang       = -1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_stage_start", 32'(stage_start), 0);
        check("reset_round_idx", 32'(round_idx), 0);
        check("reset_stage_idx", 32'(stage_idx), 0);
        rst = 1'b0;
        step();

        // Nominal: done returned 4 cycles after each start.
        begin_run(4, -1);
        while (n_done == 0 && err_cyc < 0 && cyc < 3000) step();
        check("nom_done_cycle", done_cyc, 721);
        check("nom_launches", launches, 120);
        check("nom_busy_at_done", 32'(busy), 1);
        check("nom_round_at_done", 32'(round_idx), NR - 1);
        step();
        check("nom_busy_after", 32'(busy), 0);
        check("nom_done_after", 32'(done), 0);
        check("nom_round_hold", 32'(round_idx), NR - 1);
        repeat (5) step();
        check("nom_single_done", n_done, 1);

        // Minimum latency: done seen in the first WAIT cycle.
        begin_run(1, -1);
        while (n_done == 0 && err_cyc < 0 && cyc < 3000) step();
        check("min_done_cycle", done_cyc, 361);
        check("min_launches", launches, 120);
        repeat (2) step();

        // Done arrives on the last permitted WAIT cycle: done must win over timeout.
        begin_run(8, -1);
        while (n_done == 0 && err_cyc < 0 && cyc < 3000) step();
        check("coll_done_cycle", done_cyc, 1201);
        check("coll_no_error", err_cyc, -1);
        repeat (2) step();

        // Watchdog: step 2 of round 5 (launch 27) never completes.
        begin_run(4, NS * 5 + 2);
        while (n_done == 0 && err_cyc < 0 && cyc < 3000) step();
        check("wd_launches", launches, 28);
        check("wd_error_cycle", err_cyc, last_launch + 9);
        check("wd_stage_idx", 32'(stage_idx), 2);
        check("wd_round_idx", 32'(round_idx), 5);
        check("wd_busy", 32'(busy), 1);
        repeat (4) step();
        check("wd_error_held", 32'(error), 1);
        check("wd_stage_held", 32'(stage_idx), 2);
        check("wd_round_held", 32'(round_idx), 5);
        check("wd_no_launch", 32'(stage_start), 0);
        abort = 1'b1;
        step();
        check("wd_abort_busy", 32'(busy), 0);
        check("wd_abort_error", 32'(error), 0);
        repeat (2) step();

        // Abort in round 10 WAIT, preceded by a start pulse that must be ignored.
        begin_run(4, -1);
        while (launches < NS * 10 + 1 && err_cyc < 0 && cyc < 3000) step();
        check("ab_reached_round10", launches, NS * 10 + 1);
        step();
        start = 1'b1;
        step();
        check("ab_ign_round", 32'(round_idx), 10);
        check("ab_ign_stage", 32'(stage_idx), 0);
        check("ab_ign_busy", 32'(busy), 1);
        check("ab_ign_launch", 32'(stage_start), 0);
        abort = 1'b1;
        step();
        check("ab_busy", 32'(busy), 0);
        check("ab_launch", 32'(stage_start), 0);
        check("ab_done", 32'(done), 0);
        repeat (20) step();
        check("ab_no_more_launch", launches, NS * 10 + 1);
        check("ab_no_done", n_done, 0);

        // Asynchronous reset between edges in round 3.
        begin_run(4, -1);
        while (launches < NS * 3 + 1 && err_cyc < 0 && cyc < 3000) step();
        step();
        #2 rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_launch", 32'(stage_start), 0);
        check("ar_done", 32'(done), 0);
        check("ar_error", 32'(error), 0);
        check("ar_round_idx", 32'(round_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("ar_idle_after", 32'(busy), 0);
        check("ar_no_done", n_done, 0);
        begin_run(1, -1);
        while (n_done == 0 && err_cyc < 0 && cyc < 3000) step();
        check("ar_rerun_done_cycle", done_cyc, 361);
        check("ar_rerun_launches", launches, 120);
        check("ar_rerun_no_error", err_cyc, -1);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
